// File: rtl/vgademo_pkg.sv
// vgademo_pkg: definitions shared by the vgademo effect blocks.
//   recip_state_e - sequencing state of the shared reciprocal arbiter.
//   RECIP_DW      - default denominator width of the reciprocal unit.
//   RECIP_RW      - default reciprocal result width.
//   RECIP_CYCLES  - default cycles from div_start to a valid div_recip.
package vgademo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } recip_state_e;

  localparam int RECIP_DW     = 9;
  localparam int RECIP_RW     = 11;
  localparam int RECIP_CYCLES = 16;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational one-hot round-robin picker.
// Searches the request vector starting at slot last+1 (mod N) and returns
// the first requesting slot as a one-hot grant, or zero with no requests.
// Passing last = N-1 permanently turns it into a lowest-index-wins picker.
//   req   in  N   request vector
//   last  in  IW  index of the most recent grant
//   grant out N   one-hot grant
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant
);

  always_comb begin
    int slot;
    slot  = 0;
    grant = '0;
    for (int k = 1; k <= N; k++) begin
      slot = (int'(last) + k) % N;
      // grant stays zero until the first requester in rotation order is found
      if ((grant == '0) && req[slot]) begin
        grant[slot] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/recip_arbiter.sv
// recip_arbiter: shares one iterative reciprocal unit (1/denom) between
// NREQ requesters. Requests are granted one at a time, the divider is run
// for the winner, and the result returns with a one-cycle pulse on the
// owner's rsp_valid bit. A zero denominator bypasses the divider and
// returns the saturated value (all ones) on the next cycle.
//
// Ports:
//   clk48      in   1        system clock
//   rst_n      in   1        asynchronous active-low reset
//   req_valid  in   NREQ     per-requester request
//   req_denom  in   NREQ*DW  denominators, requester i at [i*DW +: DW]
//   req_ready  out  NREQ     one-hot grant (combinational, IDLE only)
//   rsp_valid  out  NREQ     one-hot, one-cycle result pulse to the owner
//   rsp_recip  out  RW       result shared by all requesters
//   div_start  out  1        one-cycle divider start pulse
//   div_denom  out  DW       divider operand, stable for the whole RUN
//   div_recip  in   RW       divider result
//   busy       out  1        high in RUN; with two states this is the FSM state
//
// Build option: RECIP_ARB_FIXED_PRIO_EN selects strict fixed priority
// (lowest index wins); default is round-robin from last_grant+1.
//
// Handshake: a transfer happens in a cycle where req_valid[i] & req_ready[i]
// is high. A requester holds req_valid and its denominator until granted;
// dropping req_valid earlier simply withdraws the request. req_ready is
// never high outside IDLE, so requests raised during RUN wait (or vanish
// if withdrawn) without being transferred.
module recip_arbiter
  import vgademo_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int DW         = RECIP_DW,
  parameter int RW         = RECIP_RW,
  parameter int DIV_CYCLES = RECIP_CYCLES
) (
  input  logic              clk48,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*DW-1:0] req_denom,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [RW-1:0]     rsp_recip,
  output logic              div_start,
  output logic [DW-1:0]     div_denom,
  input  logic [RW-1:0]     div_recip,
  output logic              busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(DIV_CYCLES + 1);
  localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

  recip_state_e    state_q, state_d;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   pick_last;
  logic [IW-1:0]   win_idx;
  logic [DW-1:0]   win_denom;
  logic            accept;
  logic            accept_zero;
  logic            run_done;
  logic [IW-1:0]   owner_q;
  logic [DW-1:0]   denom_q;
  logic [CW-1:0]   cnt_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic [RW-1:0]   rsp_recip_q;

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .req   (req_valid),
    .last  (pick_last),
    .grant (grant)
  );

`ifdef RECIP_ARB_FIXED_PRIO_EN
  // Rotation always starts at index 0, so the lowest index always wins.
  assign pick_last = LAST_RST;
`else
  logic [IW-1:0] last_grant_q;

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= LAST_RST;
    end else if (accept) begin
      last_grant_q <= win_idx;
    end
  end

  assign pick_last = last_grant_q;
`endif

  // Gated with rst_n so no grant is visible while reset is held.
  assign req_ready = ((state_q == IDLE) && rst_n) ? grant : '0;
  assign accept    = |req_ready;

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        win_idx = IW'(i);
      end
    end
  end

  assign win_denom   = req_denom[int'(win_idx)*DW +: DW];
  assign accept_zero = accept && (win_denom == '0);
  assign run_done    = (state_q == RUN) && (cnt_q == '0);

  // State register
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !accept_zero) state_d = RUN;
      RUN:     if (run_done)               state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: the counter still holds its load value in the first RUN cycle.
  always_comb begin
    busy      = (state_q == RUN);
    div_start = (state_q == RUN) && (cnt_q == CW'(DIV_CYCLES));
  end

  // Request capture and RUN countdown. RUN lasts DIV_CYCLES+1 cycles, so
  // div_recip is sampled DIV_CYCLES cycles after div_start.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= '0;
      denom_q <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      owner_q <= win_idx;
      denom_q <= win_denom;
      cnt_q   <= CW'(DIV_CYCLES);
    end else if ((state_q == RUN) && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Response pulse and result capture.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_recip_q <= '0;
    end else begin
      rsp_valid_q <= '0;
      if (accept_zero) begin
        rsp_valid_q <= req_ready;
        rsp_recip_q <= '1;
      end else if (run_done) begin
        rsp_valid_q <= NREQ'(1) << owner_q;
        rsp_recip_q <= div_recip;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_recip = rsp_recip_q;
  assign div_denom = denom_q;

endmodule

// File: tb/tb_recip_arbiter.sv
// tb_recip_arbiter: self-checking bench for recip_arbiter.
// A stand-in divider answers div_start after DIV_CYCLES cycles and drives a
// junk value at every other time. A cycle-level reference model predicts
// grants, busy and div_start and pushes each expected response (due cycle,
// owner, value) onto exp_q; responses are popped and compared as they come
// out. A vector table and hand-written sequences add direct checks.
module tb_recip_arbiter;
  import vgademo_pkg::*;

  localparam int NREQ       = 2;
  localparam int DW         = RECIP_DW;
  localparam int RW         = RECIP_RW;
  localparam int DIV_CYCLES = RECIP_CYCLES;

  logic              clk48 = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_denom;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [RW-1:0]     rsp_recip;
  logic              div_start;
  logic [DW-1:0]     div_denom;
  logic [RW-1:0]     div_recip;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  recip_arbiter #(
    .NREQ       (NREQ),
    .DW         (DW),
    .RW         (RW),
    .DIV_CYCLES (DIV_CYCLES)
  ) dut (
    .clk48     (clk48),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_denom (req_denom),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_recip (rsp_recip),
    .div_start (div_start),
    .div_denom (div_denom),
    .div_recip (div_recip),
    .busy      (busy)
  );

  // ---------------- clock ----------------
  always #5 clk48 = ~clk48;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] model_recip(input logic [DW-1:0] d);
    logic [31:0] q;
    if (d == '0) return '1;
    q = 32'h10000 / {23'd0, d};
    return q[RW-1:0];
  endfunction

  function automatic logic [NREQ-1:0] model_pick(input logic [NREQ-1:0] v, input int last);
    logic [NREQ-1:0] g;
    g = '0;
`ifdef RECIP_ARB_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) if (v[i]) g = NREQ'(1) << i;
`else
    for (int k = NREQ; k >= 1; k--) if (v[(last + k) % NREQ]) g = NREQ'(1) << ((last + k) % NREQ);
`endif
    return g;
  endfunction

  // ---------------- stand-in divider ----------------
  logic [DW-1:0] dlat;
  int            dcnt;
  bit            dact;
  int            div_start_cnt = 0;

  always @(negedge clk48) begin
    if (!rst_n) begin
      dact = 1'b0;
      dcnt = 0;
    end else if (div_start) begin
      dact = 1'b1;
      dcnt = DIV_CYCLES;
      dlat = div_denom;
      div_start_cnt++;
    end else if (dact) begin
      if (dcnt == 0) dact = 1'b0;
      else begin
        dcnt--;
        if (dcnt == 0) check("div_denom_hold", div_denom, dlat);
      end
    end
  end

  assign div_recip = (dact && dcnt == 0) ? model_recip(dlat) : 11'h2AA;

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic [15:0]   due;
    logic [1:0]    owner;
    logic [RW-1:0] recip;
  } sb_t;
  localparam int SBW = $bits(sb_t);

  logic [SBW-1:0] exp_q[$];
  int             cyc = 0;
  int             m_run = 0;
  int             m_last = NREQ - 1;
  int             rsp1_seen = 0;
  sb_t            m_ent;
  logic [NREQ-1:0] m_g;
  logic [DW-1:0]  m_d;
  int             m_idx;

  always @(negedge clk48) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      m_run  = 0;
      m_last = NREQ - 1;
    end else begin
      if (rsp_valid[1]) rsp1_seen++;
      m_ent = '0;
      if (exp_q.size() > 0) m_ent = exp_q[0];
      if (exp_q.size() > 0 && m_ent.due == cyc[15:0]) begin
        void'(exp_q.pop_front());
        check("sb_rsp_valid", rsp_valid, NREQ'(1) << m_ent.owner);
        check("sb_rsp_recip", rsp_recip, m_ent.recip);
      end else begin
        check("sb_rsp_quiet", rsp_valid, '0);
      end
      check("sb_busy", busy, m_run != 0);
      check("sb_div_start", div_start, m_run == DIV_CYCLES + 1);
      if (m_run != 0) begin
        check("sb_ready_in_run", req_ready, '0);
        m_run--;
      end else begin
        m_g = model_pick(req_valid, m_last);
        check("sb_grant", req_ready, m_g);
        if (m_g != '0) begin
          m_idx = 0;
          for (int i = 0; i < NREQ; i++) if (m_g[i]) m_idx = i;
          m_last = m_idx;
          m_d = req_denom[m_idx*DW +: DW];
          m_ent.owner = 2'(m_idx);
          m_ent.recip = model_recip(m_d);
          if (m_d == '0) begin
            m_ent.due = 16'(cyc + 1);
          end else begin
            m_ent.due = 16'(cyc + DIV_CYCLES + 2);
            m_run = DIV_CYCLES + 1;
          end
          exp_q.push_back(m_ent);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(output logic [NREQ-1:0] g);
    g = '0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk48);
      if (|(req_valid & req_ready)) begin
        g = req_ready;
        break;
      end
    end
    if (g == '0) begin
      n_checks++;
      n_fail++;
      $display("FAIL grant_timeout: got no grant expected one within 50 cycles");
    end
    @(posedge clk48);
    #1;
  endtask

  task automatic wait_rsp(output logic [NREQ-1:0] v, output logic [RW-1:0] r);
    v = '0;
    r = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk48);
      if (rsp_valid != '0) begin
        v = rsp_valid;
        r = rsp_recip;
        break;
      end
    end
    if (v == '0) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_timeout: got no rsp_valid expected one within 40 cycles");
    end
  endtask

  task automatic drain();
    repeat (DIV_CYCLES + 6) @(posedge clk48);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, '0);
    check({tag, "_rsp_valid"}, rsp_valid, '0);
    check({tag, "_rsp_recip"}, rsp_recip, '0);
    check({tag, "_div_start"}, div_start, '0);
    check({tag, "_div_denom"}, div_denom, '0);
    check({tag, "_busy"},      busy,      '0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [NREQ-1:0] valid;
    logic [DW-1:0]   d0;
    logic [DW-1:0]   d1;
    logic [NREQ-1:0] exp_grant;
    logic [RW-1:0]   exp_recip;
    int              exp_starts;
  } vec_t;

  vec_t vecs[6];

  logic [NREQ-1:0] g, v;
  logic [RW-1:0]   r;
  int              starts0, seen1;

  initial begin
    vecs[0] = '{2'b01, 9'd100, 9'd0,   2'b01, 11'd655,  1};
    vecs[1] = '{2'b10, 9'd0,   9'd50,  2'b10, 11'd1310, 1};
    vecs[2] = '{2'b01, 9'd0,   9'd77,  2'b01, 11'h7FF,  0};
`ifdef RECIP_ARB_FIXED_PRIO_EN
    vecs[3] = '{2'b11, 9'd60,  9'd255, 2'b01, 11'd1092, 1};
`else
    vecs[3] = '{2'b11, 9'd60,  9'd255, 2'b10, 11'd257,  1};
`endif
    vecs[4] = '{2'b11, 9'd33,  9'd511, 2'b01, 11'd1985, 1};
    vecs[5] = '{2'b10, 9'd5,   9'd0,   2'b10, 11'h7FF,  0};

    rst_n     = 1'b0;
    req_valid = '0;
    req_denom = '0;
    #2;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk48);
    #1;
    rst_n = 1'b1;
    @(posedge clk48);
    #1;

    // Table: one transaction per entry.
    for (int i = 0; i < 6; i++) begin
      starts0   = div_start_cnt;
      req_valid = vecs[i].valid;
      req_denom = {vecs[i].d1, vecs[i].d0};
      wait_ready(g);
      check($sformatf("vec%0d_grant", i), g, vecs[i].exp_grant);
      req_valid = '0;
      wait_rsp(v, r);
      check($sformatf("vec%0d_owner", i), v, vecs[i].exp_grant);
      check($sformatf("vec%0d_recip", i), r, vecs[i].exp_recip);
      check($sformatf("vec%0d_starts", i), div_start_cnt - starts0, vecs[i].exp_starts);
      @(posedge clk48);
      #1;
    end

    // Both requesters held continuously: back-to-back results.
    req_denom = {9'd60, 9'd50};
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_rsp(v, r);
`ifdef RECIP_ARB_FIXED_PRIO_EN
      check($sformatf("both_owner%0d", k), v, 2'b01);
      check($sformatf("both_recip%0d", k), r, 11'd1310);
`else
      check($sformatf("both_owner%0d", k), v, (k % 2 == 0) ? 2'b01 : 2'b10);
      check($sformatf("both_recip%0d", k), r, (k % 2 == 0) ? 11'd1310 : 11'd1092);
`endif
    end
    @(posedge clk48);
    #1;
    req_valid = '0;
    drain();

    // Requester 1 pulses once during RUN: no transfer.
    seen1     = rsp1_seen;
    req_denom = {9'd77, 9'd100};
    req_valid = 2'b01;
    wait_ready(g);
    check("pulse_grant", g, 2'b01);
    req_valid = '0;
    repeat (3) @(posedge clk48);
    #1;
    req_valid = 2'b10;
    @(posedge clk48);
    #1;
    req_valid = '0;
    wait_rsp(v, r);
    check("pulse_owner", v, 2'b01);
    check("pulse_recip", r, 11'd655);
    drain();
    check("pulse_no_rsp1", rsp1_seen - seen1, 0);

    // Reset in RUN cycle 8 with both requesters waiting.
    req_denom = {9'd60, 9'd100};
    req_valid = 2'b01;
    wait_ready(g);
    check("rst_first_grant", g, 2'b01);
    req_valid = 2'b11;
    repeat (7) @(posedge clk48);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun");
    repeat (2) @(posedge clk48);
    #1;
    rst_n = 1'b1;
    @(negedge clk48);
    check("post_rst_grant", req_ready, 2'b01);
    @(posedge clk48);
    #1;
    req_valid = '0;
    wait_rsp(v, r);
    check("post_rst_owner", v, 2'b01);
    check("post_rst_recip", r, 11'd655);
    drain();

    check("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test expected finish before 100000ns");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/recip_arbiter.md
# recip_arbiter

Shares one iterative reciprocal unit (the `recip16`-style `1/denom` divider used for per-scanline plane stepping) between several requesters, e.g. the floor plane and a projected-object effect, both computing their next-line step during hblank. Requests are arbitrated round-robin and sequenced through the divider one at a time. Each result is returned to its owner with a one-cycle valid pulse. The block sits between the effect generators and the single divider instance in `vgademo`.

## Interface
Parameters:
- `NREQ`, 2: number of requesters (2..4).
- `DW`, 9: denominator width.
- `RW`, 11: reciprocal result width.
- `DIV_CYCLES`, 16: cycles from `div_start` to a valid `div_recip`.

Ports:
- `clk48`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NREQ  per-requester request.
- `req_denom`  in  NREQ*DW  denominators; requester i at bits [i*DW +: DW].
- `req_ready`  out  NREQ  one-hot grant; the transfer happens on `req_valid[i] & req_ready[i]`.
- `rsp_valid`  out  NREQ  one-hot one-cycle result pulse to the owner.
- `rsp_recip`  out  RW  result, shared by all requesters; meaningful only while `rsp_valid` is nonzero.
- `div_start`  out  1  one-cycle start pulse to the divider.
- `div_denom`  out  DW  divider operand; held stable from `div_start` until the result is captured.
- `div_recip`  in  RW  divider result.
- `busy`  out  1  high in RUN.

## Operation
States:
- **IDLE**
  - `req_ready` is combinational: it is the one-hot winner among `req_valid`, or 0 if there are no requests.
  - An accept latches the winner index (`owner`) and its denominator.
  - Nonzero denominator: go to RUN.
  - Zero denominator: do not start the divider; stay in IDLE and pulse the zero-denominator response next cycle.
- **RUN**
  - `div_start` is high in the first RUN cycle only.
  - A down-counter is loaded with `DIV_CYCLES`.
  - When the counter reaches 0, capture `div_recip` into `rsp_recip`, pulse `rsp_valid[owner]` next cycle, and return to IDLE.
- `req_ready` is 0 in RUN.

Arbitration:
- Round-robin. Priority starts at `last_grant+1` mod `NREQ`.
- `last_grant` updates on every accept, including zero-denominator accepts.
- After reset `last_grant = NREQ-1`, so requester 0 wins first.

Zero denominator: `rsp_recip` = all ones (saturated reciprocal).

Requester rules:
- A requester must hold `req_valid` and `req_denom` until granted.
- Dropping `req_valid` before a grant is legal; no transfer occurs.
- `req_valid` asserted while that requester's own response is pending is legal; it is arbitrated normally on return to IDLE.

Arithmetic: no width conversion; `div_denom` is the latched `req_denom` slice, and `rsp_recip` is `div_recip` unmodified.

## Timing
- Reset values: state IDLE, `req_ready` 0 (no requests are possible until reset releases), `rsp_valid` 0, `rsp_recip` 0, `div_start` 0, `div_denom` 0, `busy` 0, `last_grant` NREQ-1.
- Nonzero accept in cycle t:
  - `div_start` at t+1.
  - `div_recip` sampled at t+1+`DIV_CYCLES`.
  - `rsp_valid` at t+2+`DIV_CYCLES`.
  - IDLE in the same cycle as `rsp_valid`, so a new accept can coincide with the pulse.
  - Throughput: one result per `DIV_CYCLES`+2 cycles.
- Zero-denominator accept at t: `rsp_valid` at t+1; the next accept is possible at t+1.
- Simultaneous requests resolve in one cycle; the losers see `req_ready` 0 and keep waiting.
- Reset asserted mid-RUN: the in-flight result is discarded, no `rsp_valid` is issued, and outputs return to reset values asynchronously.

## Configuration
- `RECIP_ARB_FIXED_PRIO_EN` defined: strict fixed priority, where the lowest index always wins and `last_grant` is unused. Used so the floor plane (index 0) can never miss its hblank deadline.
- Undefined (default): round-robin as described above.

## Structure
- Shared package `vgademo_pkg` holds the state enum (IDLE, RUN) and the default constants `RECIP_DW`, `RECIP_RW`, `RECIP_CYCLES`.
- One sub-module, `rr_pick`: a combinational one-hot round-robin picker (inputs request vector and `last_grant`; output one-hot grant), also instantiated by future arbiters.
- The divider is instantiated outside this block, never inside it.

## Test plan
- Reset release, `req_valid`=01, denom=100: `req_ready`=01 at t, `div_start` at t+1, `rsp_valid`=01 at t+18 (`DIV_CYCLES`=16) with `rsp_recip` equal to the model's 1/100 value.
- Both requesters held continuously, denoms 50/60: grants alternate 0,1,0,1; results return in that order, each to the correct owner.
- Requester 0 denom=0: `rsp_valid`=01 with `rsp_recip`=0x7FF one cycle after accept, and no `div_start`.
- `rst_n` pulled low at RUN cycle 8: all outputs 0 immediately; after release, no stale `rsp_valid`, and requester 0 is granted first.
- With `RECIP_ARB_FIXED_PRIO_EN`, both requesters held: requester 0 is granted on every accept and requester 1 is never granted.
- `req_valid[1]` pulsed one cycle while the arbiter is in RUN: no transfer and no `rsp_valid[1]`.
